uart_wb_master: RTL

Command executor between the UART command decoder and the Wishbone bus. Consumes one 34-bit decoded command word per strobe and runs a single-beat Wishbone B4 pipelined master cycle: address set, write, or read. Produces a 34-bit response word with a valid/ready handshake for the UART response encoder feeding the TX path. Holds the address register, with optional auto-increment.

---
 rtl/uart_wb_master_if.sv | 40 ++++
 rtl/uart_wb_master.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_wb_master_if.sv
// Purpose: groups the command, response and Wishbone signals of uart_wb_master.
// Ports: command strobe/word, response valid/ready/word, Wishbone B4 pipelined master bus.
// Modports: master = executor view, slave = decoder/encoder/bus-slave view.
interface uart_wb_master_if;
    // command from the UART decoder
    logic        i_stb;
    logic [33:0] i_word;
    // status
    logic        o_busy;
    logic        o_overrun;
    // response to the UART encoder
    logic        o_rsp_stb;
    logic [33:0] o_rsp_word;
    logic        i_rsp_ready;
    // Wishbone master side
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [29:0] o_wb_addr;
    logic [31:0] o_wb_data;
    logic [3:0]  o_wb_sel;
    logic        i_wb_stall;
    logic        i_wb_ack;
    logic        i_wb_err;
    logic [31:0] i_wb_data;

    modport master (
        input  i_stb, i_word, i_rsp_ready,
        input  i_wb_stall, i_wb_ack, i_wb_err, i_wb_data,
        output o_busy, o_overrun, o_rsp_stb, o_rsp_word,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel
    );

    modport slave (
        output i_stb, i_word, i_rsp_ready,
        output i_wb_stall, i_wb_ack, i_wb_err, i_wb_data,
        input  o_busy, o_overrun, o_rsp_stb, o_rsp_word,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel
    );
endinterface

// File: rtl/uart_wb_master.sv
// Purpose: executes decoded UART commands (set address / write / read / nop) as single-beat
//          Wishbone B4 pipelined cycles and returns one response word per command.
// Latency: SET_ADDR/NOP respond one edge after the strobe; bus ops respond the edge after ack/err/timeout.
// Backpressure: the response is held until i_rsp_ready; strobes while busy are dropped and flagged by o_overrun.
// Ports: i_clk, i_reset (sync, active-high), bus (uart_wb_master_if.master).
module uart_wb_master #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    uart_wb_master_if.master       bus
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUS_REQ  = 2'd1,
        BUS_WAIT = 2'd2,
        RESP     = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_SET_ADDR = 2'b00,
        OP_WRITE    = 2'b01,
        OP_READ     = 2'b10,
        OP_NOP      = 2'b11
    } op_t;

    localparam logic [1:0] RSP_ADDR  = 2'b00;
    localparam logic [1:0] RSP_WRITE = 2'b01;
    localparam logic [1:0] RSP_READ  = 2'b10;
    localparam logic [1:0] RSP_ERR   = 2'b11;

    state_t        state, state_nxt;
    logic [29:0]   addr, addr_nxt;
    logic          inc_en, inc_en_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          wb_cyc, wb_cyc_nxt;
    logic          wb_stb, wb_stb_nxt;
    logic          wb_we, wb_we_nxt;
    logic [29:0]   wb_addr, wb_addr_nxt;
    logic [31:0]   wb_data, wb_data_nxt;
    logic [33:0]   rsp_word, rsp_word_nxt;
    logic          overrun, overrun_nxt;

    // Helper terms used by the FSM
    logic [CW-1:0] cnt_inc;
    logic          term;
    logic          bus_done;
    logic          bus_timeout;
    op_t           cmd_op;
    logic [31:0]   cmd_payload;

    assign cnt_inc     = cnt + 1'b1;
    assign term        = bus.i_wb_ack | bus.i_wb_err;
    assign cmd_op      = op_t'(bus.i_word[33:32]);
    assign cmd_payload = bus.i_word[31:0];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= IDLE;
            addr     <= '0;
            inc_en   <= 1'b0;
            cnt      <= '0;
            wb_cyc   <= 1'b0;
            wb_stb   <= 1'b0;
            wb_we    <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            rsp_word <= '0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_nxt;
            addr     <= addr_nxt;
            inc_en   <= inc_en_nxt;
            cnt      <= cnt_nxt;
            wb_cyc   <= wb_cyc_nxt;
            wb_stb   <= wb_stb_nxt;
            wb_we    <= wb_we_nxt;
            wb_addr  <= wb_addr_nxt;
            wb_data  <= wb_data_nxt;
            rsp_word <= rsp_word_nxt;
            overrun  <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        addr_nxt     = addr;
        inc_en_nxt   = inc_en;
        cnt_nxt      = cnt;
        wb_cyc_nxt   = wb_cyc;
        wb_stb_nxt   = wb_stb;
        wb_we_nxt    = wb_we;
        wb_addr_nxt  = wb_addr;
        wb_data_nxt  = wb_data;
        rsp_word_nxt = rsp_word;
        bus_done     = 1'b0;
        bus_timeout  = 1'b0;
        // Any strobe outside IDLE is a dropped command
        overrun_nxt  = bus.i_stb && (state != IDLE);

        case (state)
            IDLE: begin
                if (bus.i_stb) begin
                    case (cmd_op)
                        OP_SET_ADDR: begin
                            addr_nxt     = cmd_payload[29:0];
                            inc_en_nxt   = cmd_payload[30];
                            rsp_word_nxt = {RSP_ADDR, 1'b0, cmd_payload[30], cmd_payload[29:0]};
                            state_nxt    = RESP;
                        end
                        OP_NOP: begin
                            rsp_word_nxt = {RSP_ADDR, 1'b0, inc_en, addr};
                            state_nxt    = RESP;
                        end
                        default: begin
                            wb_cyc_nxt  = 1'b1;
                            wb_stb_nxt  = 1'b1;
                            wb_we_nxt   = (cmd_op == OP_WRITE);
                            wb_addr_nxt = addr;
                            if (cmd_op == OP_WRITE) begin
                                wb_data_nxt = cmd_payload;
                            end
                            cnt_nxt     = '0;
                            state_nxt   = BUS_REQ;
                        end
                    endcase
                end
            end
            BUS_REQ: begin
                cnt_nxt = cnt_inc;
                // An ack/err only belongs to this request once the slave has taken it (stall low)
                if (!bus.i_wb_stall && term) begin
                    bus_done = 1'b1;
                end else if (cnt_inc == CW'(TIMEOUT_CYCLES)) begin
                    bus_timeout = 1'b1;
                end else if (!bus.i_wb_stall) begin
                    wb_stb_nxt = 1'b0;
                    state_nxt  = BUS_WAIT;
                end
            end
            BUS_WAIT: begin
                cnt_nxt = cnt_inc;
                if (term) begin
                    bus_done = 1'b1;
                end else if (cnt_inc == CW'(TIMEOUT_CYCLES)) begin
                    bus_timeout = 1'b1;
                end
            end
            RESP: begin
                if (bus.i_rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Common bus-cycle termination: close the cycle and build the response
        if (bus_done || bus_timeout) begin
            wb_cyc_nxt = 1'b0;
            wb_stb_nxt = 1'b0;
            wb_we_nxt  = 1'b0;
            state_nxt  = RESP;
            if (bus_timeout || bus.i_wb_err) begin
                // err wins over a simultaneous ack; address is left untouched
                rsp_word_nxt = {RSP_ERR, 2'b00, addr};
            end else begin
                if (wb_we) begin
                    rsp_word_nxt = {RSP_WRITE, wb_data};
                end else begin
                    rsp_word_nxt = {RSP_READ, bus.i_wb_data};
                end
                if (inc_en) begin
                    addr_nxt = addr + 30'd1;
                end
            end
        end
    end

    assign bus.o_busy     = (state != IDLE);
    assign bus.o_overrun  = overrun;
    assign bus.o_rsp_stb  = (state == RESP);
    assign bus.o_rsp_word = rsp_word;
    assign bus.o_wb_cyc   = wb_cyc;
    assign bus.o_wb_stb   = wb_stb;
    assign bus.o_wb_we    = wb_we;
    assign bus.o_wb_addr  = wb_addr;
    assign bus.o_wb_data  = wb_data;
    assign bus.o_wb_sel   = 4'hF;

endmodule
